// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime baud divisor, parity and stop bits, with glitch/framing/parity/overrun checks.
// Latency: rdy one clock after the last stop sample; no backpressure, a frame completing while rdy is high sets overrun.
module uart_rx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    input  logic              clr_rdy,
    output logic              rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic              r_par_en;
    logic              r_par_odd;
    logic              r_two;
    logic [3:0]        r_bcnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_ferr;
    logic              r_perr;
    logic              w_sample;
    logic              w_done;
    logic              w_start;
    logic              w_last_data;
    logic              w_last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_start     = (r_state == IDLE) && !r_rx_s;
    assign w_sample    = (r_state != IDLE) && (r_cnt == '0);
    assign w_last_data = (r_bcnt == 4'(DATA_W - 1));
    assign w_last_stop = !r_two || (r_bcnt == 4'd1);
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            IDLE:   if (!r_rx_s) w_next = START;
            START:  if (w_sample) w_next = r_rx_s ? IDLE : DATA;
            DATA:   if (w_sample && w_last_data) w_next = r_par_en ? PARITY : STOP;
            PARITY: if (w_sample) w_next = STOP;
            STOP: begin
                if (w_sample && w_last_stop) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Configuration is captured on leaving IDLE so mid-frame changes cannot corrupt a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div     <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_two     <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= baud_div >> 1;
            r_div     <= baud_div;
            r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            r_par_odd <= (parity_mode == 2'b10);
            r_two     <= two_stop;
        end else if (r_state != IDLE) begin
            if (w_sample) r_cnt <= r_div - DIV_W'(1);
            else          r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_start) begin
            r_bcnt <= '0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                DATA: begin
                    r_shift <= {r_rx_s, r_shift[DATA_W-1:1]};
                    r_bcnt  <= w_last_data ? 4'd0 : r_bcnt + 4'd1;
                end
                PARITY: r_perr <= (^r_shift) ^ r_rx_s ^ r_par_odd;
                STOP: begin
                    r_ferr <= r_ferr | !r_rx_s;
                    r_bcnt <= r_bcnt + 4'd1;
                end
                default: r_bcnt <= '0;
            endcase
        end
    end

    // A completing frame takes priority over a coincident acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy        <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_done) begin
            rdy        <= 1'b1;
            rx_data    <= r_shift;
            frame_err  <= r_ferr | !r_rx_s;
            parity_err <= r_perr;
            overrun    <= clr_rdy ? 1'b0 : (overrun | rdy);
        end else if (clr_rdy) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8-bit instance (a) and a 7-bit instance (b) driven with directed and random frames.
module tb_uart_rx_cfg;

    logic        clk;
    logic        rst_n_a, rx_a, two_a, clr_a;
    logic [15:0] div_a;
    logic [1:0]  pm_a;
    logic        rdy_a, fe_a, pe_a, ov_a, busy_a;
    logic [7:0]  data_a;

    logic        rst_n_b, rx_b, two_b, clr_b;
    logic [15:0] div_b;
    logic [1:0]  pm_b;
    logic        rdy_b, fe_b, pe_b, ov_b, busy_b;
    logic [6:0]  data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_a  = -1;
    logic prev_rdy_a = 1'b0;

    uart_rx_cfg #(.DATA_W(8), .DIV_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .RX(rx_a), .baud_div(div_a), .parity_mode(pm_a),
        .two_stop(two_a), .clr_rdy(clr_a), .rdy(rdy_a), .rx_data(data_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_cfg #(.DATA_W(7), .DIV_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .RX(rx_b), .baud_div(div_b), .parity_mode(pm_b),
        .two_stop(two_b), .clr_rdy(clr_b), .rdy(rdy_b), .rx_data(data_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_a && !prev_rdy_a) rise_a = cyc;
        prev_rdy_a = rdy_a;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input bit sel, input int d, input logic [1:0] pm, input bit two);
        if (sel) begin div_b = 16'(d); pm_b = pm; two_b = two; end
        else     begin div_a = 16'(d); pm_a = pm; two_a = two; end
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int div);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (div) @(posedge clk);
        #1;
    endtask

    // Line-level frame: start, data LSB first, optional parity, one or two stop bits.
    task automatic send_frame(input bit sel, input int width, input logic [8:0] data, input int div,
                              input logic [1:0] pm, input bit two, input bit bad_par,
                              input logic [1:0] bad_stop);
        logic p;
        set_cfg(sel, div, pm, two);
        drive_bit(sel, 1'b0, div);
        set_cfg(sel, $urandom_range(4, 40), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        p = 1'b0;
        for (int i = 0; i < width; i++) begin
            p ^= data[i];
            drive_bit(sel, data[i], div);
        end
        set_cfg(sel, div, pm, two);
        if (pm == 2'b01 || pm == 2'b10) begin
            if (pm == 2'b10) p = ~p;
            drive_bit(sel, p ^ bad_par, div);
        end
        drive_bit(sel, ~bad_stop[0], div);
        if (two) drive_bit(sel, ~bad_stop[1], div);
    endtask

    task automatic settle(input bit sel, input int idle_cycles);
        int n;
        drive_bit(sel, 1'b1, idle_cycles);
        n = 0;
        while ((sel ? busy_b : busy_a) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", sel ? busy_b : busy_a, 1'b0);
    endtask

    task automatic ack(input bit sel);
        if (sel) clr_b = 1'b1;
        else     clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    initial begin
        int t0;
        logic [7:0] d;
        int dv;
        logic [1:0] pm, bs;
        bit two, bp;

        rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        set_cfg(1'b0, 16, 2'b00, 1'b0);
        set_cfg(1'b1, 5, 2'b10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", rdy_a, 1'b0);
        check("rst_data", data_a, 8'h00);
        check("rst_fe", fe_a, 1'b0);
        check("rst_pe", pe_a, 1'b0);
        check("rst_ov", ov_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 at 16 clocks/bit; falling edge seen at edge t0+1, rdy 155 clocks later.
        rise_a = -1;
        t0 = cyc;
        send_frame(1'b0, 8, 9'h0A5, 16, 2'b00, 1'b0, 1'b0, 2'b00);
        settle(1'b0, 32);
        check("a5_data", data_a, 8'hA5);
        check("a5_rdy", rdy_a, 1'b1);
        check("a5_fe", fe_a, 1'b0);
        check("a5_pe", pe_a, 1'b0);
        check("a5_latency", rise_a - t0, 1 + 155);
        ack(1'b0);
        check("ack_rdy", rdy_a, 1'b0);

        send_frame(1'b0, 8, 9'h037, 16, 2'b01, 1'b0, 1'b0, 2'b00);
        settle(1'b0, 32);
        check("even_ok_pe", pe_a, 1'b0);
        ack(1'b0);
        send_frame(1'b0, 8, 9'h037, 16, 2'b01, 1'b0, 1'b1, 2'b00);
        settle(1'b0, 32);
        check("even_bad_pe", pe_a, 1'b1);
        check("even_bad_data", data_a, 8'h37);
        ack(1'b0);

        send_frame(1'b0, 8, 9'h05A, 16, 2'b00, 1'b0, 1'b0, 2'b01);
        settle(1'b0, 32);
        check("stop_low_fe", fe_a, 1'b1);
        check("stop_low_rdy", rdy_a, 1'b1);
        check("stop_low_data", data_a, 8'h5A);
        ack(1'b0);
        check("ack_keeps_fe", fe_a, 1'b1);
        send_frame(1'b0, 8, 9'h03C, 16, 2'b00, 1'b0, 1'b0, 2'b00);
        settle(1'b0, 32);
        check("good_after_fe", fe_a, 1'b0);
        ack(1'b0);

        // Short low pulse must be rejected at the start-bit sample.
        drive_bit(1'b0, 1'b0, 4);
        rx_a = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_busy", busy_a, 1'b1);
        settle(1'b0, 16);
        check("glitch_rdy", rdy_a, 1'b0);
        check("glitch_fe", fe_a, 1'b0);
        check("glitch_pe", pe_a, 1'b0);

        send_frame(1'b0, 8, 9'h011, 16, 2'b00, 1'b0, 1'b0, 2'b00);
        send_frame(1'b0, 8, 9'h022, 16, 2'b00, 1'b0, 1'b0, 2'b00);
        settle(1'b0, 32);
        check("b2b_data", data_a, 8'h22);
        check("b2b_ov", ov_a, 1'b1);
        check("b2b_rdy", rdy_a, 1'b1);
        ack(1'b0);
        check("b2b_ack_rdy", rdy_a, 1'b0);
        check("b2b_ack_ov", ov_a, 1'b0);

        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom_range(0, 255));
            dv  = $urandom_range(4, 20);
            pm  = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            bp  = 1'($urandom_range(0, 1));
            bs  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(1'b0, 8, {1'b0, d}, dv, pm, two, bp, bs);
            settle(1'b0, 2 * dv);
            check("rnd_data", data_a, d);
            check("rnd_rdy", rdy_a, 1'b1);
            check("rnd_pe", pe_a, ((pm == 2'b01) || (pm == 2'b10)) && bp);
            check("rnd_fe", fe_a, bs[0] || (two && bs[1]));
            check("rnd_ov", ov_a, 1'b0);
            ack(1'b0);
        end

        // 7-bit instance: odd parity, two stop bits, 5 clocks/bit.
        send_frame(1'b1, 7, 9'h02B, 5, 2'b10, 1'b1, 1'b0, 2'b00);
        settle(1'b1, 10);
        check("b_pre_data", data_b, 7'h2B);
        check("b_pre_rdy", rdy_b, 1'b1);
        fork
            send_frame(1'b1, 7, 9'h07F, 5, 2'b10, 1'b1, 1'b0, 2'b00);
        join_none
        repeat (20) @(posedge clk);
        #1;
        check("b_mid_busy", busy_b, 1'b1);
        rst_n_b = 1'b0;
        #1;
        check("b_rst_rdy", rdy_b, 1'b0);
        check("b_rst_data", data_b, 7'h00);
        check("b_rst_fe", fe_b, 1'b0);
        check("b_rst_pe", pe_b, 1'b0);
        check("b_rst_ov", ov_b, 1'b0);
        check("b_rst_busy", busy_b, 1'b0);
        repeat (70) @(posedge clk);
        #1;
        rst_n_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(1'b1, 7, 9'h041, 5, 2'b10, 1'b1, 1'b0, 2'b00);
        settle(1'b1, 10);
        check("b41_data", data_b, 7'h41);
        check("b41_rdy", rdy_b, 1'b1);
        check("b41_fe", fe_b, 1'b0);
        check("b41_pe", pe_b, 1'b0);
        ack(1'b1);
        send_frame(1'b1, 7, 9'h041, 5, 2'b10, 1'b1, 1'b1, 2'b10);
        settle(1'b1, 10);
        check("b41_stop2_fe", fe_b, 1'b1);
        check("b41_odd_pe", pe_b, 1'b1);
        check("b41_stop2_data", data_b, 7'h41);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
